// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master transaction sequencer.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, AACK, WDATA, WACK, RDATA, RACK, STOP
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit tick divider: one tick every CLK_DIV clocks while enabled,
// held cleared while disabled so the first tick lands CLK_DIV clocks after enable.
module i2c_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_master_ctrl.sv
// I2C master transaction sequencer: START, address+R/W, ACK, data bytes, STOP.
// All bus timing is owned here; state and phase advance on quarter ticks only.
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int NB_W    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            go,
    input  logic [6:0]      addrIn,
    input  logic            rw,
    input  logic [NB_W-1:0] nbytes,
    input  logic [7:0]      wdata,
    output logic            wreq,
    output logic [7:0]      rdata,
    output logic            rvalid,
    input  logic            iSDA,
    output logic            oSDA,
    output logic            sda_oe,
    output logic            scl,
    output logic            busy,
    output logic            done,
    output logic            nack
);

    logic            tick;
    state_t          state;
    logic [1:0]      ph;
    logic [2:0]      bitcnt;
    logic [NB_W-1:0] cnt;
    logic [7:0]      sh;
    logic [7:0]      wbuf;
    logic            rw_q;
    logic            ack_smp;

    i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (busy),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ph      <= Q0;
            bitcnt  <= '0;
            cnt     <= '0;
            sh      <= '0;
            wbuf    <= '0;
            rw_q    <= 1'b0;
            ack_smp <= ACK;
            scl     <= 1'b1;
            oSDA    <= 1'b1;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            nack    <= 1'b0;
            wreq    <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
        end else begin
            done   <= 1'b0;
            wreq   <= 1'b0;
            rvalid <= 1'b0;
            // Host answers wreq in this cycle; SCL is still low in q0 of WDATA.
            if (wreq) begin
                sda_oe <= 1'b1;
                oSDA   <= wdata[7];
                sh     <= {wdata[6:0], 1'b0};
            end
            if (state == IDLE) begin
                if (go) begin
                    state  <= START;
                    ph     <= Q0;
                    bitcnt <= '0;
                    sh     <= {addrIn, rw};
                    rw_q   <= rw;
                    cnt    <= nbytes;
                    wbuf   <= wdata;
                    nack   <= 1'b0;
                    busy   <= 1'b1;
                    sda_oe <= 1'b1;
                    oSDA   <= 1'b1;
                    scl    <= 1'b1;
                end
            end else if (tick) begin
                if (ph != Q3) begin
                    ph  <= ph + 2'd1;
                    scl <= (state == START) || (ph == Q1) || (ph == Q2);
                    if (ph == Q2 && state == RDATA) sh <= {sh[6:0], iSDA};
                    if (ph == Q2 && (state == AACK || state == WACK)) ack_smp <= iSDA;
                    if (state == START && ph == Q1) oSDA <= 1'b0;
                    if (state == STOP && ph == Q2) oSDA <= 1'b1;
                end else begin
                    ph  <= Q0;
                    scl <= 1'b0;
                    case (state)
                        START: begin
                            state <= ADDR;
                            oSDA  <= sh[7];
                            sh    <= {sh[6:0], 1'b0};
                        end
                        ADDR, WDATA: begin
                            if (bitcnt == 3'd7) begin
                                bitcnt <= '0;
                                state  <= (state == ADDR) ? AACK : WACK;
                                sda_oe <= 1'b0;
                            end else begin
                                bitcnt <= bitcnt + 3'd1;
                                oSDA   <= sh[7];
                                sh     <= {sh[6:0], 1'b0};
                            end
                        end
                        AACK: begin
                            if (ack_smp == NACK || cnt == '0) begin
                                nack   <= (ack_smp == NACK);
                                state  <= STOP;
                                sda_oe <= 1'b1;
                                oSDA   <= 1'b0;
                            end else if (rw_q) begin
                                state <= RDATA;
                            end else begin
                                state  <= WDATA;
                                sda_oe <= 1'b1;
                                oSDA   <= wbuf[7];
                                sh     <= {wbuf[6:0], 1'b0};
                            end
                        end
                        WACK: begin
                            cnt <= cnt - NB_W'(1);
                            if (ack_smp == NACK || cnt == NB_W'(1)) begin
                                nack   <= (ack_smp == NACK);
                                state  <= STOP;
                                sda_oe <= 1'b1;
                                oSDA   <= 1'b0;
                            end else begin
                                state <= WDATA;
                                wreq  <= 1'b1;
                            end
                        end
                        RDATA: begin
                            if (bitcnt == 3'd7) begin
                                bitcnt <= '0;
                                state  <= RACK;
                                rdata  <= sh;
                                rvalid <= 1'b1;
                                sda_oe <= 1'b1;
                                oSDA   <= (cnt == NB_W'(1)) ? NACK : ACK;
                            end else begin
                                bitcnt <= bitcnt + 3'd1;
                            end
                        end
                        RACK: begin
                            cnt <= cnt - NB_W'(1);
                            if (cnt == NB_W'(1)) begin
                                state <= STOP;
                                oSDA  <= 1'b0;
                            end else begin
                                state  <= RDATA;
                                sda_oe <= 1'b0;
                            end
                        end
                        STOP: begin
                            state  <= IDLE;
                            scl    <= 1'b1;
                            oSDA   <= 1'b1;
                            sda_oe <= 1'b0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl with a small bit-level slave on a wired-AND SDA line.
module tb_i2c_master_ctrl;

    logic       clk;
    logic       rst;
    logic       go;
    logic [6:0] addrIn;
    logic       rw;
    logic [3:0] nbytes;
    logic [7:0] wdata;
    logic       wreq;
    logic [7:0] rdata;
    logic       rvalid;
    logic       iSDA;
    logic       oSDA;
    logic       sda_oe;
    logic       scl;
    logic       busy;
    logic       done;
    logic       nack;

    logic       slave_sda;
    logic       sda_line;

    i2c_master_ctrl #(.CLK_DIV(4), .NB_W(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .go     (go),
        .addrIn (addrIn),
        .rw     (rw),
        .nbytes (nbytes),
        .wdata  (wdata),
        .wreq   (wreq),
        .rdata  (rdata),
        .rvalid (rvalid),
        .iSDA   (iSDA),
        .oSDA   (oSDA),
        .sda_oe (sda_oe),
        .scl    (scl),
        .busy   (busy),
        .done   (done),
        .nack   (nack)
    );

    assign sda_line = (sda_oe ? oSDA : 1'b1) & slave_sda;
    assign iSDA     = sda_line;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Slave configuration
    logic       addr_ack_bit;
    logic [7:0] rbytes [16];
    logic       wacks  [16];
    logic [7:0] wbytes [$];

    // Per-transaction observations
    logic       seen [$];
    logic [7:0] rx [$];
    int         n_wreq;
    int         n_done;
    int         lat;
    logic       busy0;
    logic       stop_seen;

    function automatic logic slave_bit(int n, logic r, int nb);
        int k, j, i;
        if (n < 8) return 1'b1;
        if (n == 8) return addr_ack_bit;
        k = n - 9;
        j = k / 9;
        i = k % 9;
        if (j >= nb) return 1'b1;
        if (r) return (i < 8) ? rbytes[j][7-i] : 1'b1;
        return (i < 8) ? 1'b1 : wacks[j];
    endfunction

    function automatic logic [7:0] get_byte(int s);
        logic [7:0] b;
        b = 8'hxx;
        for (int i = 0; i < 8; i++)
            if (s + i < seen.size()) b[7-i] = seen[s+i];
        return b;
    endfunction

    function automatic logic get_bit(int i);
        return (i < seen.size()) ? seen[i] : 1'bx;
    endfunction

    task automatic run_xfer(input logic [6:0] a, input logic r, input logic [3:0] nb,
                            input logic [7:0] w0, input bit mid_go);
        int   nrise;
        int   wi;
        logic prev_scl;
        logic prev_line;
        logic line;
        seen.delete();
        rx.delete();
        n_wreq = 0; n_done = 0; lat = -1; nrise = 0; wi = 0; stop_seen = 1'b0;
        slave_sda = 1'b1;
        @(negedge clk);
        addrIn = a; rw = r; nbytes = nb; wdata = w0; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        busy0 = busy;
        prev_scl = scl;
        prev_line = sda_line;
        for (int c = 1; c <= 2000 && lat < 0; c++) begin
            @(negedge clk);
            line = sda_line;
            if (mid_go && c == 100) begin
                go = 1'b1; addrIn = ~a; rw = ~r; nbytes = 4'd5; wdata = 8'hEE;
            end else begin
                go = 1'b0;
            end
            if (!prev_scl && scl) begin
                seen.push_back(line);
                nrise++;
            end
            if (prev_scl && !scl) slave_sda = slave_bit(nrise, r, int'(nb));
            if (prev_scl && scl && !prev_line && line) stop_seen = 1'b1;
            if (wreq) begin
                n_wreq++;
                wdata = (wi < wbytes.size()) ? wbytes[wi] : 8'h00;
                wi++;
            end
            if (rvalid) rx.push_back(rdata);
            if (done) begin
                lat = c;
                n_done++;
            end
            prev_scl = scl;
            prev_line = line;
        end
        slave_sda = 1'b1;
        go = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (scl !== 1'b1 || oSDA !== 1'b1 || sda_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pads: scl=%b oSDA=%b sda_oe=%b, required 1 1 0", scl, oSDA, sda_oe);
        end
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || nack !== 1'b0 || wreq !== 1'b0 || rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy=%b done=%b nack=%b wreq=%b rvalid=%b, required all 0",
                     busy, done, nack, wreq, rvalid);
        end
        n_checks++;
        if (rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h required 00", rdata);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || scl !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b scl=%b, required 0 1", busy, scl);
        end
    endtask

    task automatic test_write1();
        addr_ack_bit = 1'b0;
        wacks[0] = 1'b0;
        wbytes.delete();
        run_xfer(7'h41, 1'b0, 4'd1, 8'hA5, 1'b0);
        n_checks++;
        if (busy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL write1_busy_rise: got %b required 1", busy0);
        end
        n_checks++;
        if (get_byte(0) !== 8'h82) begin
            n_fail++;
            $display("FAIL write1_addr: got %h required 82", get_byte(0));
        end
        n_checks++;
        if (get_byte(9) !== 8'hA5) begin
            n_fail++;
            $display("FAIL write1_data: got %h required a5", get_byte(9));
        end
        n_checks++;
        if (lat != 320) begin
            n_fail++;
            $display("FAIL write1_latency: got %0d required 320", lat);
        end
        n_checks++;
        if (nack !== 1'b0 || n_wreq != 0 || stop_seen !== 1'b1) begin
            n_fail++;
            $display("FAIL write1_end: nack=%b wreq=%0d stop=%b, required 0 0 1", nack, n_wreq, stop_seen);
        end
    endtask

    task automatic test_addr_nack();
        addr_ack_bit = 1'b1;
        wbytes.delete();
        run_xfer(7'h41, 1'b0, 4'd1, 8'hA5, 1'b0);
        n_checks++;
        if (nack !== 1'b1) begin
            n_fail++;
            $display("FAIL addr_nack_flag: got %b required 1", nack);
        end
        n_checks++;
        if (lat != 176) begin
            n_fail++;
            $display("FAIL addr_nack_latency: got %0d required 176", lat);
        end
        n_checks++;
        if (n_wreq != 0 || seen.size() != 10 || stop_seen !== 1'b1) begin
            n_fail++;
            $display("FAIL addr_nack_shape: wreq=%0d rises=%0d stop=%b, required 0 10 1",
                     n_wreq, seen.size(), stop_seen);
        end
        addr_ack_bit = 1'b0;
    endtask

    task automatic test_read2();
        addr_ack_bit = 1'b0;
        rbytes[0] = 8'h3C;
        rbytes[1] = 8'h96;
        run_xfer(7'h2A, 1'b1, 4'd2, 8'h00, 1'b0);
        n_checks++;
        if (get_byte(0) !== 8'h55) begin
            n_fail++;
            $display("FAIL read2_addr: got %h required 55", get_byte(0));
        end
        n_checks++;
        if (rx.size() != 2) begin
            n_fail++;
            $display("FAIL read2_rvalid_count: got %0d required 2", rx.size());
        end else begin
            n_checks++;
            if (rx[0] !== 8'h3C || rx[1] !== 8'h96) begin
                n_fail++;
                $display("FAIL read2_rdata: got %h %h required 3c 96", rx[0], rx[1]);
            end
        end
        n_checks++;
        if (get_bit(17) !== 1'b0 || get_bit(26) !== 1'b1) begin
            n_fail++;
            $display("FAIL read2_master_ack: got %b %b required 0 1", get_bit(17), get_bit(26));
        end
        n_checks++;
        if (lat != 464 || nack !== 1'b0 || stop_seen !== 1'b1) begin
            n_fail++;
            $display("FAIL read2_end: lat=%0d nack=%b stop=%b, required 464 0 1", lat, nack, stop_seen);
        end
    endtask

    task automatic test_write3();
        addr_ack_bit = 1'b0;
        for (int i = 0; i < 3; i++) wacks[i] = 1'b0;
        wbytes = '{8'h22, 8'h33};
        run_xfer(7'h41, 1'b0, 4'd3, 8'h11, 1'b0);
        n_checks++;
        if (n_wreq != 2) begin
            n_fail++;
            $display("FAIL write3_wreq_count: got %0d required 2", n_wreq);
        end
        n_checks++;
        if (get_byte(9) !== 8'h11 || get_byte(18) !== 8'h22 || get_byte(27) !== 8'h33) begin
            n_fail++;
            $display("FAIL write3_data: got %h %h %h required 11 22 33",
                     get_byte(9), get_byte(18), get_byte(27));
        end
        n_checks++;
        if (lat != 608 || nack !== 1'b0) begin
            n_fail++;
            $display("FAIL write3_end: lat=%0d nack=%b, required 608 0", lat, nack);
        end
        wbytes.delete();
    endtask

    task automatic test_probe_ignore();
        int extra_busy;
        addr_ack_bit = 1'b0;
        run_xfer(7'h50, 1'b0, 4'd0, 8'h00, 1'b1);
        n_checks++;
        if (get_byte(0) !== 8'hA0) begin
            n_fail++;
            $display("FAIL probe_addr: got %h required a0", get_byte(0));
        end
        n_checks++;
        if (lat != 176 || seen.size() != 10 || nack !== 1'b0) begin
            n_fail++;
            $display("FAIL probe_end: lat=%0d rises=%0d nack=%b, required 176 10 0",
                     lat, seen.size(), nack);
        end
        extra_busy = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (busy || done) extra_busy++;
        end
        n_checks++;
        if (extra_busy != 0 || n_done != 1) begin
            n_fail++;
            $display("FAIL probe_second_xfer: busy_cycles=%0d dones=%0d, required 0 1", extra_busy, n_done);
        end
    endtask

    task automatic test_reset_mid();
        slave_sda = 1'b1;
        @(negedge clk);
        addrIn = 7'h41; rw = 1'b0; nbytes = 4'd1; wdata = 8'hA5; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (70) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || sda_oe !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre_reset: busy=%b sda_oe=%b, required 1 1", busy, sda_oe);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (scl !== 1'b1 || sda_oe !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_release: scl=%b sda_oe=%b busy=%b, required 1 0 0", scl, sda_oe, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        addr_ack_bit = 1'b0;
        wacks[0] = 1'b0;
        run_xfer(7'h41, 1'b0, 4'd1, 8'hA5, 1'b0);
        n_checks++;
        if (get_byte(0) !== 8'h82 || get_byte(9) !== 8'hA5) begin
            n_fail++;
            $display("FAIL mid_reset_retry_bytes: got %h %h required 82 a5", get_byte(0), get_byte(9));
        end
        n_checks++;
        if (lat != 320 || nack !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_retry_end: lat=%0d nack=%b, required 320 0", lat, nack);
        end
    endtask

    initial begin
        rst = 1'b1; go = 1'b0; addrIn = '0; rw = 1'b0; nbytes = '0; wdata = '0;
        slave_sda = 1'b1; addr_ack_bit = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rbytes[i] = 8'hFF;
            wacks[i]  = 1'b0;
        end
        test_reset();
        test_write1();
        test_addr_nack();
        test_read2();
        test_write3();
        test_probe_ignore();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
